// File: rtl/add_sweep_checker.sv
// Exhaustive sweep checker for a WIDTH-bit combinational adder: drives every operand pair,
// counts mismatches and captures the first one. ADD_CHK_STOP_ON_ERR_EN stops at first mismatch.
module add_sweep_checker #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   num1,
  output logic [WIDTH-1:0]   num2,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic               cout_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic [WIDTH:0]     first_err_got
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  // Counter counts down to zero, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   num1_q, num1_d, num2_q, num2_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic [WIDTH:0]     fg_q, fg_d;

  logic [WIDTH:0]     expected;
  logic [WIDTH:0]     got;
  logic               mismatch;
  logic               last_pair;
  logic               advance;

  assign expected  = {1'b0, num1_q} + {1'b0, num2_q};
  assign got       = {cout_in, sum_in};
  assign mismatch  = (got != expected);
  assign last_pair = (&num1_q) && (&num2_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fg_d    = fg_q;
    advance = 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
          num1_d  = '0;
          num2_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          fg_d    = '0;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) state_d = StSample;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = num1_q;
            fb_d = num2_q;
            fg_d = got;
          end
        end
`ifdef ADD_CHK_STOP_ON_ERR_EN
        if (mismatch) advance = 1'b0;
`endif
        if (!advance) begin
          state_d = StDone;
        end else begin
          num2_d  = num2_q + 1'b1;
          if (&num2_q) num1_d = num1_q + 1'b1;
          cnt_d   = SettleLoad;
          state_d = last_pair ? StDone : StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fg_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fg_q    <= fg_d;
    end
  end

  assign num1            = num1_q;
  assign num2            = num2_q;
  assign busy            = (state_q == StSettle) || (state_q == StSample);
  assign done            = (state_q == StDone);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_a     = fa_q;
  assign first_err_b     = fb_q;
  assign first_err_got   = fg_q;

endmodule

// File: tb/tb_add_sweep_checker.sv
// Bench for add_sweep_checker: an adder with selectable faults, a whole-sweep outcome model
// and a per-cycle compare of the operand walk and final results.
module tb_add_sweep_checker;
  localparam int W  = 4;
  localparam int S  = 1;
  localparam int NP = 1 << (2 * W);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   num1, num2, sum_in;
  logic           cout_in;
  logic           busy, done, pass, first_err_valid;
  logic [2*W:0]   err_count;
  logic [W-1:0]   first_err_a, first_err_b;
  logic [W:0]     first_err_got;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int k      = 0;
  int mode   = 0;
  bit track  = 1'b0;
  int ct, cp;

  int           exp_err, exp_tend;
  logic         exp_fv;
  logic [W-1:0] exp_a, exp_b, exp_n1, exp_n2;
  logic [W:0]   exp_got;

  add_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num1            (num1),
    .num2            (num2),
    .sum_in          (sum_in),
    .cout_in         (cout_in),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_a     (first_err_a),
    .first_err_b     (first_err_b),
    .first_err_got   (first_err_got)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode 0: ideal, 1: cout stuck-at-0, 2: out[0] inverted.
  function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input int m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1) s[W] = 1'b0;
    if (m == 2) s[0] = ~s[0];
    return s;
  endfunction

  always_comb {cout_in, sum_in} = adder(num1, num2, mode);

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Outcome of a whole sweep against the faulty adder, from plain arithmetic.
  function automatic void model(input int m);
    logic [W-1:0] a, b;
    logic [W:0]   g;
    int           truth;
    bit           stopped;
    exp_err = 0; exp_fv = 1'b0; exp_a = '0; exp_b = '0; exp_got = '0;
    exp_n1 = '0; exp_n2 = '0; exp_tend = NP * (S + 1); stopped = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (!stopped) begin
        a = W'(i >> W);
        b = W'(i);
        truth = (i >> W) + (i % (1 << W));
        g = adder(a, b, m);
        if (int'(g) != truth) begin
          exp_err++;
          if (!exp_fv) begin
            exp_fv = 1'b1; exp_a = a; exp_b = b; exp_got = g;
          end
`ifdef ADD_CHK_STOP_ON_ERR_EN
          exp_tend = (i + 1) * (S + 1);
          exp_n1 = a; exp_n2 = b;
          stopped = 1'b1;
`endif
        end
      end
    end
  endfunction

  // Pair index t/(S+1) is on the operands t cycles after the start edge; done at exp_tend.
  always @(negedge clk) begin
    if (track) begin
      ct = cyc - k;
      if (ct >= 0 && ct < exp_tend) begin
        cp = ct / (S + 1);
        chk("walk", {busy, done, num1, num2}, {1'b1, 1'b0, W'(cp >> W), W'(cp)});
      end else if (ct == exp_tend) begin
        chk("final",
            {done, busy, pass, first_err_valid, first_err_a, first_err_b, first_err_got,
             err_count, num1, num2},
            {1'b1, 1'b0, (exp_err == 0), exp_fv, exp_a, exp_b, exp_got,
             (2*W+1)'(exp_err), exp_n1, exp_n2});
        track = 1'b0;
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk(nm, {num1, num2, busy, done, pass, err_count, first_err_valid, first_err_a,
             first_err_b, first_err_got}, 64'd0);
  endtask

  task automatic run_sweep(input int m, input bit pulses, input bit abort);
    mode = m;
    model(m);
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    track = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (abort) begin
      repeat (199) @(negedge clk);
      track = 1'b0;
      rst_n = 1'b0;
      #1 chk_zero("abort_reset");
      @(negedge clk);
      chk_zero("abort_hold");
      rst_n = 1'b1;
      return;
    end
    if (pulses) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (289) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < exp_tend + 20 && track; i++) @(negedge clk);
    #1;
    if (track) begin
      chk("timeout", 64'd1, 64'd0);
      track = 1'b0;
    end
  endtask

  initial begin
    #12 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    model(0);
    chk("model_ideal", {32'(exp_err), 32'(exp_tend)}, {32'd0, 32'd512});
`ifdef ADD_CHK_STOP_ON_ERR_EN
    model(1);
    chk("model_cout", {32'(exp_err), 32'(exp_tend)}, {32'd1, 32'd64});
`else
    model(1);
    chk("model_cout", {32'(exp_err), 23'd0, exp_a, exp_b, exp_got}, {32'd120, 23'd0, 4'd1,
                                                                     4'd15, 5'd0});
`endif

    run_sweep(0, 1'b0, 1'b0);
    chk("ideal_lit", {pass, err_count, first_err_valid, num1, num2}, {1'b1, 9'd0, 1'b0, 8'd0});

    run_sweep(1, 1'b0, 1'b0);
`ifdef ADD_CHK_STOP_ON_ERR_EN
    chk("cout_lit", {err_count, num1, num2, pass, first_err_got}, {9'd1, 4'd1, 4'd15, 1'b0,
                                                                 5'd0});
`else
    chk("cout_lit", {err_count, first_err_a, first_err_b, first_err_got, pass},
        {9'd120, 4'd1, 4'd15, 5'd0, 1'b0});
`endif

    run_sweep(2, 1'b0, 1'b0);
`ifdef ADD_CHK_STOP_ON_ERR_EN
    chk("out0_lit", {err_count, first_err_a, first_err_b, first_err_got}, {9'd1, 8'd0, 5'd1});
`else
    chk("out0_lit", {err_count, first_err_a, first_err_b, first_err_got}, {9'd256, 8'd0, 5'd1});
`endif

    run_sweep(0, 1'b1, 1'b0);
    chk("pulses_lit", {pass, done, err_count}, {1'b1, 1'b1, 9'd0});

    run_sweep(0, 1'b0, 1'b1);
    run_sweep(0, 1'b0, 1'b0);
    chk("restart_lit", {pass, done, busy, err_count}, {1'b1, 1'b1, 1'b0, 9'd0});

    // Results hold in DONE without start.
    repeat (5) @(negedge clk);
    chk("done_hold", {pass, done, busy, num1, num2}, {1'b1, 1'b1, 1'b0, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
